// File: rtl/tnew_pipe_if.sv
// tnew_pipe_if: decode-side inputs and per-stage outputs of the D->E->M->W
// Tnew pipeline, bundled for the pipeline block and the hazard controller.
//   master : drives stall and the *_D fields, observes the E/M/W fields
//   slave  : the pipeline itself (consumes *_D, produces E/M/W)
interface tnew_pipe_if #(
  parameter int DW     = 32,
  parameter int TNEW_W = 4
);
  logic              stall;
  logic [DW-1:0]     instr_D;
  logic [DW-1:0]     pc_D;
  logic [TNEW_W-1:0] tnew_D;
  logic [4:0]        writereg_D;

  logic [DW-1:0]     instr_E, instr_M, instr_W;
  logic [DW-1:0]     pc_E, pc_M, pc_W;
  logic [TNEW_W-1:0] tnew_E, tnew_M, tnew_W;
  logic [4:0]        writereg_E, writereg_M, writereg_W;
  logic              valid_E, valid_M, valid_W;

  modport master (
    output stall, instr_D, pc_D, tnew_D, writereg_D,
    input  instr_E, instr_M, instr_W, pc_E, pc_M, pc_W,
           tnew_E, tnew_M, tnew_W, writereg_E, writereg_M, writereg_W,
           valid_E, valid_M, valid_W
  );

  modport slave (
    input  stall, instr_D, pc_D, tnew_D, writereg_D,
    output instr_E, instr_M, instr_W, pc_E, pc_M, pc_W,
           tnew_E, tnew_M, tnew_W, writereg_E, writereg_M, writereg_W,
           valid_E, valid_M, valid_W
  );
endinterface

// File: rtl/tnew_pipe.sv
// tnew_pipe: pipeline register chain for the D->E, E->M and M->W boundaries.
// Carries instr, pc, destination register and Tnew forward every cycle,
// decrements Tnew (saturating at 0) per stage, and loads a bubble into E
// while decode is stalled.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears all stages
//   pipe  : tnew_pipe_if.slave (stall + D inputs in, E/M/W fields out)
module tnew_pipe #(
  parameter int TNEW_W = 4,
  parameter int DW     = 32
) (
  input  logic             clk,
  input  logic             reset,
  tnew_pipe_if.slave       pipe
);

  typedef struct packed {
    logic              valid;
    logic [DW-1:0]     instr;
    logic [DW-1:0]     pc;
    logic [TNEW_W-1:0] tnew;
    logic [4:0]        writereg;
  } stage_t;

  stage_t e_d, e_q;
  stage_t m_d, m_q;
  stage_t w_d, w_q;

  // Saturating decrement: a finished result stays at 0, never wraps.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    logic [TNEW_W-1:0] r;
    if (t == {TNEW_W{1'b0}}) begin
      r = {TNEW_W{1'b0}};
    end else begin
      r = t - {{(TNEW_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // E next-state: bubble on stall, otherwise capture decode; $0 writes never carry Tnew.
  always_comb begin
    e_d = '0;
    if (pipe.stall) begin
      e_d = '0;
    end else begin
      e_d.valid    = 1'b1;
      e_d.instr    = pipe.instr_D;
      e_d.pc       = pipe.pc_D;
      e_d.writereg = pipe.writereg_D;
      if (pipe.writereg_D == 5'd0) begin
        e_d.tnew = {TNEW_W{1'b0}};
      end else begin
        e_d.tnew = pipe.tnew_D;
      end
    end
  end

  // M and W next-state: plain shift with Tnew decremented, independent of stall.
  always_comb begin
    m_d      = e_q;
    m_d.tnew = tnew_dec(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = tnew_dec(m_q.tnew);
  end

  // Stage registers; reset wins over stall and shift and flushes everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign pipe.instr_E    = e_q.instr;
  assign pipe.pc_E       = e_q.pc;
  assign pipe.tnew_E     = e_q.tnew;
  assign pipe.writereg_E = e_q.writereg;
  assign pipe.valid_E    = e_q.valid;

  assign pipe.instr_M    = m_q.instr;
  assign pipe.pc_M       = m_q.pc;
  assign pipe.tnew_M     = m_q.tnew;
  assign pipe.writereg_M = m_q.writereg;
  assign pipe.valid_M    = m_q.valid;

  assign pipe.instr_W    = w_q.instr;
  assign pipe.pc_W       = w_q.pc;
  assign pipe.tnew_W     = w_q.tnew;
  assign pipe.writereg_W = w_q.writereg;
  assign pipe.valid_W    = w_q.valid;

endmodule

// File: tb/tb_tnew_pipe.sv
// tb_tnew_pipe: directed self-checking bench for tnew_pipe. Each step pushes
// the expected E contents into a history queue; after the edge the last three
// entries give the expected E/M/W contents (older ones aged by their depth).
module tb_tnew_pipe;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  tnew;
    logic [4:0]  writereg;
  } stage_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  stage_t hist[$];

  tnew_pipe_if #(.DW(32), .TNEW_W(4)) bus ();

  tnew_pipe #(.TNEW_W(4), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .pipe  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stage_t age(input stage_t s, input int n);
    stage_t r;
    r = s;
    if (int'(s.tnew) > n) r.tnew = s.tnew - 4'(n);
    else                  r.tnew = 4'd0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stage(input string tag, input stage_t obs, input stage_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, record the expected E entry, then check all stages.
  task automatic step(input logic rst, input logic stl, input logic [31:0] ins,
                      input logic [31:0] pcv, input logic [3:0] tn, input logic [4:0] wr);
    stage_t e;
    stage_t oe, om, ow;
    reset          = rst;
    bus.stall      = stl;
    bus.instr_D    = ins;
    bus.pc_D       = pcv;
    bus.tnew_D     = tn;
    bus.writereg_D = wr;
    e = '0;
    if (rst) begin
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
    end else if (!stl) begin
      e.valid    = 1'b1;
      e.instr    = ins;
      e.pc       = pcv;
      e.writereg = wr;
      e.tnew     = (wr == 5'd0) ? 4'd0 : tn;
    end
    hist.push_back(e);
    while (hist.size() > 3) void'(hist.pop_front());
    @(posedge clk);
    #1;
    oe = {bus.valid_E, bus.instr_E, bus.pc_E, bus.tnew_E, bus.writereg_E};
    om = {bus.valid_M, bus.instr_M, bus.pc_M, bus.tnew_M, bus.writereg_M};
    ow = {bus.valid_W, bus.instr_W, bus.pc_W, bus.tnew_W, bus.writereg_W};
    chk_stage("stage_E", oe, hist[2]);
    chk_stage("stage_M", om, age(hist[1], 1));
    chk_stage("stage_W", ow, age(hist[0], 2));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.stall   = 1'b0;
    bus.instr_D = 32'd0;
    bus.pc_D    = 32'd0;
    bus.tnew_D  = 4'd0;
    bus.writereg_D = 5'd0;

    // Reset for two edges with live D inputs
    step(1'b1, 1'b0, 32'hDEADBEEF, 32'h00001234, 4'd3, 5'd9);
    step(1'b1, 1'b0, 32'hDEADBEEF, 32'h00001234, 4'd3, 5'd9);
    chk("rst_valid_E", {31'd0, bus.valid_E}, 32'd0);
    chk("rst_pc_W", bus.pc_W, 32'd0);

    // lw-style load, then nops
    step(1'b0, 1'b0, 32'h8C220004, 32'h00003000, 4'd2, 5'd2);
    chk("lw_tnew_E", {28'd0, bus.tnew_E}, 32'd2);
    chk("lw_reg_E", {27'd0, bus.writereg_E}, 32'd2);
    chk("release_valid_M", {31'd0, bus.valid_M}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'h00003004, 4'd0, 5'd0);
    chk("lw_tnew_M", {28'd0, bus.tnew_M}, 32'd1);
    chk("lw_pc_M", bus.pc_M, 32'h00003000);
    step(1'b0, 1'b0, 32'd0, 32'h00003008, 4'd0, 5'd0);
    chk("lw_tnew_W", {28'd0, bus.tnew_W}, 32'd0);
    chk("lw_reg_W", {27'd0, bus.writereg_W}, 32'd2);
    chk("lw_pc_W", bus.pc_W, 32'h00003000);

    // Saturation at 0
    step(1'b0, 1'b0, 32'h00A52820, 32'h0000300C, 4'd0, 5'd5);
    chk("sat_tnew_E", {28'd0, bus.tnew_E}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'h00003010, 4'd0, 5'd0);
    chk("sat_tnew_M", {28'd0, bus.tnew_M}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'h00003014, 4'd0, 5'd0);
    chk("sat_tnew_W", {28'd0, bus.tnew_W}, 32'd0);

    // Write to $0 carries no Tnew
    step(1'b0, 1'b0, 32'h8C000008, 32'h00003018, 4'd3, 5'd0);
    chk("zero_tnew_E", {28'd0, bus.tnew_E}, 32'd0);
    chk("zero_valid_E", {31'd0, bus.valid_E}, 32'd1);

    // Stall: B in E, A held in D for two edges
    step(1'b0, 1'b0, 32'h8C2B0000, 32'h00003000, 4'd2, 5'd11);
    step(1'b0, 1'b1, 32'h016B6020, 32'h00003004, 4'd1, 5'd12);
    chk("stall1_valid_E", {31'd0, bus.valid_E}, 32'd0);
    chk("stall1_pc_M", bus.pc_M, 32'h00003000);
    step(1'b0, 1'b1, 32'h016B6020, 32'h00003004, 4'd1, 5'd12);
    chk("stall2_instr_E", bus.instr_E, 32'd0);
    chk("stall2_pc_W", bus.pc_W, 32'h00003000);
    chk("stall2_valid_M", {31'd0, bus.valid_M}, 32'd0);
    step(1'b0, 1'b0, 32'h016B6020, 32'h00003004, 4'd1, 5'd12);
    chk("resume_pc_E", bus.pc_E, 32'h00003004);
    chk("resume_valid_E", {31'd0, bus.valid_E}, 32'd1);

    // Reset mid-stream with three valid instructions and stall asserted
    step(1'b0, 1'b0, 32'h11111111, 32'h00003008, 4'd3, 5'd1);
    step(1'b0, 1'b0, 32'h22222222, 32'h0000300C, 4'd2, 5'd3);
    step(1'b1, 1'b1, 32'h33333333, 32'h00003010, 4'd1, 5'd4);
    chk("midrst_valid_W", {31'd0, bus.valid_W}, 32'd0);
    chk("midrst_reg_M", {27'd0, bus.writereg_M}, 32'd0);
    step(1'b0, 1'b0, 32'h44444444, 32'h00003014, 4'd2, 5'd6);
    chk("post_rst_valid_E", {31'd0, bus.valid_E}, 32'd1);
    chk("post_rst_valid_M", {31'd0, bus.valid_M}, 32'd0);

    // Out-of-range Tnew still follows the decrement rule
    step(1'b0, 1'b0, 32'h55555555, 32'h00003018, 4'd9, 5'd7);
    step(1'b0, 1'b0, 32'd0, 32'h0000301C, 4'd0, 5'd0);
    step(1'b0, 1'b0, 32'd0, 32'h00003020, 4'd0, 5'd0);
    chk("big_tnew_W", {28'd0, bus.tnew_W}, 32'd7);
    step(1'b0, 1'b0, 32'd0, 32'h00003024, 4'd0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tnew_pipe.md
Name: tnew_pipe

Overview:
- Pipeline register chain for the D->E, E->M and M->W boundaries of the five-stage core.
- Carries each instruction's instr, pc, destination register and Tnew value forward every cycle.
- Decrements Tnew per stage and inserts a bubble into E when decode is stalled.
- Drives the tnew_E/M/W and writereg_E/M/W inputs of the hazard controller; its stall input is that controller's stalld output.

Parameters:
- TNEW_W, 4, width of all Tnew fields.
- DW, 32, width of the instr and pc fields.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  decode stalled; load a bubble into E this edge
- instr_D  input  DW  instruction leaving D
- pc_D  input  DW  PC of instr_D
- tnew_D  input  TNEW_W  cycles after E-entry until the result is ready (0 = no result)
- writereg_D  input  5  destination register of instr_D (0 = no write)
- instr_E, instr_M, instr_W  output  DW  per-stage instruction
- pc_E, pc_M, pc_W  output  DW  per-stage PC
- tnew_E, tnew_M, tnew_W  output  TNEW_W  remaining cycles until the result is produced
- writereg_E, writereg_M, writereg_W  output  5  per-stage destination register
- valid_E, valid_M, valid_W  output  1  stage holds a real instruction (not bubble/reset)

Behaviour:
- All outputs are registered and update only on the rising clk edge. There is no combinational path from input to output.
- Reset (reset=1 at an edge):
  - every output goes to 0 in all three stages, including the valid bits;
  - reset has priority over stall and over the shift;
  - reset asserted mid-stream discards all in-flight instructions on that same edge.
- E load, on a non-reset edge:
  - stall=1: E loads a bubble. instr/pc/tnew/writereg are all 0 and valid_E=0.
  - stall=0: E loads the D inputs and valid_E=1.
  - if writereg_D==0, tnew_E loads 0 regardless of tnew_D. A write to $0 is never a hazard source.
- M and W shift, on every non-reset edge, independent of stall:
  - M takes E and W takes M;
  - instr, pc, writereg and valid are copied unchanged;
  - tnew_next = (tnew==0) ? 0 : tnew-1, which saturates at 0 and never wraps to all-ones.
- Latency: a D instruction appears in E 1 edge later, in M after 2, in W after 3.
- Bubbles are ordinary stages:
  - they propagate through M and W with all fields 0;
  - their writereg of 0 guarantees the controller ignores them.
- Consecutive stall cycles:
  - each stalled edge inserts one more bubble into E;
  - the instruction already in E still advances to M, so the pipeline drains behind the stalled decode.
- Stall on the edge where E already holds a bubble: E receives another bubble. This is legal and has no side effects.
- Value ranges:
  - the only tnew_D values produced by decode are 0..3;
  - larger values are still handled by the same decrement rule.

Test Plan:
- Reset: drive reset=1 for 2 cycles with nonzero D inputs and stall=0 -> every E/M/W output reads 0 and valid_E/M/W=0; first edge after release loads E only.
- Shift/decrement: load lw-style instr_D=32'h8C220004, pc_D=32'h3000, tnew_D=2, writereg_D=2, stall=0, then feed nops -> E: tnew 2, reg 2; next edge M: tnew 1, reg 2, pc 3000; next W: tnew 0, reg 2, pc 3000.
- Saturation: tnew_D=0 with writereg_D=5 -> tnew_E=0, tnew_M=0, tnew_W=0, with no wrap to 4'hF.
- $0 destination: tnew_D=3, writereg_D=0 -> tnew_E=0, writereg_E=0, valid_E=1.
- Stall bubble: with instr A (pc 3004) in D and instr B (pc 3000) in E, assert stall for 2 cycles -> E shows two bubbles (all 0, valid_E=0), B moves into M then W, and A enters E with its own fields on the first edge after stall drops.
- Reset mid-stream: three valid instructions in flight, assert reset for 1 edge with stall=1 -> all stages 0 and invalid; normal loading resumes on the following edge.
